// File: rtl/ema_channel_scheduler.sv
// ---------------------------------------------------------------------------
// ema_channel_scheduler
//
// Shares one exponential-averager datapath between NUM_CH requesting
// channels. Each channel owns a 1-deep sample buffer, a pending flag and a
// filter state y[i]. A round-robin arbiter picks the next pending channel and
// a three-state FSM computes
//     y_new = (sample * ALPHA) + (y * BETA)      (Q1.15, 16-bit wrap)
// using a single 16x16 signed multiplier, once per MUL state.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset_n      synchronous active-low reset (highest priority)
//   clear        synchronous flush: zeroes filter states, buffers, pend, acc
//   in_valid     per-channel sample valid
//   in_data      packed Q1.15 samples, channel i at [16i+15:16i]
//   in_ready     per-channel ready, inverse of the pending flag
//   out_valid    one-cycle pulse per filtered result
//   out_channel  channel index of the result (held between pulses)
//   out_data     filtered Q1.15 value (held between pulses)
// ---------------------------------------------------------------------------
module ema_channel_scheduler #(
    parameter int                 NUM_CH = 4,
    parameter logic signed [15:0] ALPHA  = 16'sh0CCC,
    parameter logic signed [15:0] BETA   = 16'sh7333,
    localparam int                CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic [NUM_CH-1:0]    in_valid,
    input  logic [16*NUM_CH-1:0] in_data,
    output logic [NUM_CH-1:0]    in_ready,
    output logic                 out_valid,
    output logic [CH_W-1:0]      out_channel,
    output logic [15:0]          out_data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MUL_FF = 2'd1,
        ST_MUL_FB = 2'd2
    } state_t;

    state_t            state_r;
    state_t            next_state_s;

    logic [15:0]       sample_buf_r [NUM_CH];
    logic [15:0]       y_r          [NUM_CH];
    logic [NUM_CH-1:0] pend_r;
    logic [15:0]       acc_r;
    logic [CH_W-1:0]   ch_r;
    logic [CH_W-1:0]   last_grant_r;
    logic              out_valid_r;
    logic [CH_W-1:0]   out_channel_r;
    logic [15:0]       out_data_r;

    logic              grant_found_s;
    logic [CH_W-1:0]   grant_ch_s;
    logic              grant_s;
    logic              ff_en_s;
    logic              fb_en_s;
    logic [15:0]       mul_a_s;
    logic [15:0]       mul_b_s;
    logic [31:0]       product_s;
    logic [15:0]       scaled_s;
    logic [15:0]       y_new_s;

    assign in_ready    = ~pend_r;
    assign out_valid   = out_valid_r;
    assign out_channel = out_channel_r;
    assign out_data    = out_data_r;

    // Round-robin search: first pending channel strictly after last_grant_r.
    always_comb begin
        int sum_v;
        int idx_v;
        grant_found_s = 1'b0;
        grant_ch_s    = last_grant_r;
        sum_v         = 0;
        idx_v         = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            sum_v = int'(last_grant_r) + k;
            idx_v = (sum_v >= NUM_CH) ? (sum_v - NUM_CH) : sum_v;
            if (pend_r[idx_v] && !grant_found_s) begin
                grant_found_s = 1'b1;
                grant_ch_s    = CH_W'(idx_v);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // FSM next-state and per-state datapath enables.
    always_comb begin
        next_state_s = state_r;
        grant_s      = 1'b0;
        ff_en_s      = 1'b0;
        fb_en_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s) begin
                    grant_s      = 1'b1;
                    next_state_s = ST_MUL_FF;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_MUL_FF: begin
                ff_en_s      = 1'b1;
                next_state_s = ST_MUL_FB;
            end
            ST_MUL_FB: begin
                fb_en_s      = 1'b1;
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Operand select for the single shared multiplier.
    always_comb begin
        mul_a_s = 16'h0000;
        mul_b_s = 16'h0000;
        if (state_r == ST_MUL_FB) begin
            mul_a_s = y_r[ch_r];
            mul_b_s = BETA;
        end else begin
            mul_a_s = sample_buf_r[ch_r];
            mul_b_s = ALPHA;
        end
    end

    // Sign-extended operands give the correct low 32 bits of the signed
    // product; bits [30:15] are the floor-truncated Q1.15 result.
    assign product_s = {{16{mul_a_s[15]}}, mul_a_s} * {{16{mul_b_s[15]}}, mul_b_s};
    assign scaled_s  = product_s[30:15];
    assign y_new_s   = acc_r + scaled_s;

    // FSM state register; clear aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else if (clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Channel buffers, filter states, arbiter pointer and result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sample_buf_r[i] <= 16'h0000;
                y_r[i]          <= 16'h0000;
            end
            pend_r        <= '0;
            acc_r         <= 16'h0000;
            ch_r          <= '0;
            last_grant_r  <= CH_W'(NUM_CH - 1);
            out_valid_r   <= 1'b0;
            out_channel_r <= '0;
            out_data_r    <= 16'h0000;
        end else if (clear) begin
            // last_grant, ch and the held result are deliberately kept.
            for (int i = 0; i < NUM_CH; i++) begin
                sample_buf_r[i] <= 16'h0000;
                y_r[i]          <= 16'h0000;
            end
            pend_r      <= '0;
            acc_r       <= 16'h0000;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            // in_ready is ~pend_r, so a full buffer is never overwritten.
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_valid[i] && !pend_r[i]) begin
                    pend_r[i]       <= 1'b1;
                    sample_buf_r[i] <= in_data[16*i +: 16];
                end
            end
            if (grant_s) begin
                ch_r         <= grant_ch_s;
                last_grant_r <= grant_ch_s;
            end
            // pend of the served channel is already set, so no set/clear race.
            if (ff_en_s) begin
                acc_r        <= scaled_s;
                pend_r[ch_r] <= 1'b0;
            end
            if (fb_en_s) begin
                y_r[ch_r]     <= y_new_s;
                out_data_r    <= y_new_s;
                out_channel_r <= ch_r;
                out_valid_r   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ema_channel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ema_channel_scheduler
//
// Directed bench for ema_channel_scheduler with NUM_CH = 4 and default
// coefficients. Expected values are hand-computed Q1.15 results:
//   0x4000*ALPHA -> 0x0666, 0x0666*BETA -> 0x05C2, sum 0x0C28,
//   0xC000*ALPHA -> 0xF99A.
// ---------------------------------------------------------------------------
module tb_ema_channel_scheduler;

    localparam int NUM_CH = 4;

    logic                 clk;
    logic                 reset_n;
    logic                 clear;
    logic [NUM_CH-1:0]    in_valid;
    logic [16*NUM_CH-1:0] in_data;
    logic [NUM_CH-1:0]    in_ready;
    logic                 out_valid;
    logic [1:0]           out_channel;
    logic [15:0]          out_data;

    int cmp_cnt;
    int err_cnt;
    int exp_rr [6] = '{0, 2, 3, 0, 2, 3};

    ema_channel_scheduler #(.NUM_CH(NUM_CH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_channel (out_channel),
        .out_data    (out_data)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        cmp_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Present a sample on the masked channels for exactly one rising edge.
    task automatic send(input logic [3:0] mask, input logic [15:0] d);
        in_valid = mask;
        for (int i = 0; i < NUM_CH; i++) in_data[16*i +: 16] = d;
        @(posedge clk); #1;
        in_valid = '0;
    endtask

    // Wait (bounded) for the next result pulse and check latency, channel, data.
    task automatic expect_result(input string tag, input int exp_ch, input logic [15:0] exp_d, input int exp_lat);
        int lat;
        logic got;
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (!got) begin
                @(posedge clk); #1;
                if (out_valid) begin
                    got = 1'b1;
                    lat = k;
                end
            end
        end
        check_val({tag, "_seen"}, 32'(got), 32'd1);
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_ch"}, 32'(out_channel), 32'(exp_ch));
        check_val({tag, "_data"}, 32'(out_data), 32'(exp_d));
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val({tag, "_ov"}, 32'(out_valid), 32'd0);
        check_val({tag, "_od"}, 32'(out_data), 32'd0);
        check_val({tag, "_oc"}, 32'(out_channel), 32'd0);
        check_val({tag, "_rdy"}, 32'(in_ready), 32'hF);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        cmp_cnt  = 0;
        err_cnt  = 0;
        reset_n  = 1'b0;
        clear    = 1'b0;
        in_valid = '0;
        in_data  = '0;

        // Reset values.
        do_reset("rst0");

        // Single-channel latency and accumulation on ch0.
        send(4'b0001, 16'h4000);
        check_val("ch0_busy", 32'(in_ready), 32'hE);
        expect_result("ch0_first", 0, 16'h0666, 3);
        @(posedge clk); #1;
        check_val("pulse_one_cycle", 32'(out_valid), 32'd0);
        check_val("data_held", 32'(out_data), 32'h0666);
        send(4'b0001, 16'h4000);
        expect_result("ch0_second", 0, 16'h0C28, 3);

        // Negative sample truncation on ch1.
        send(4'b0010, 16'hC000);
        expect_result("ch1_neg", 1, 16'hF99A, 3);

        // All four channels at once: order, spacing and ready release.
        do_reset("rst1");
        send(4'b1111, 16'h4000);
        check_val("all_busy", 32'(in_ready), 32'h0);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NUM_CH; i++) exp_rdy[i] = (k >= 2 + 3*i);
            exp_ov = ((k % 3) == 0);
            check_val($sformatf("all_rdy_k%0d", k), 32'(in_ready), 32'(exp_rdy));
            check_val($sformatf("all_ov_k%0d", k), 32'(out_valid), 32'(exp_ov));
            if (exp_ov) begin
                check_val($sformatf("all_ch_k%0d", k), 32'(out_channel), 32'(k/3 - 1));
                check_val($sformatf("all_data_k%0d", k), 32'(out_data), 32'h0666);
            end
        end

        // Round-robin fairness with ch0, ch2, ch3 streaming.
        in_valid = 4'b1101;
        in_data  = '0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (n < 6) begin
                @(posedge clk); #1;
                if (out_valid) begin
                    check_val($sformatf("rr_%0d", n), 32'(out_channel), 32'(exp_rr[n]));
                    n++;
                end
            end
        end
        check_val("rr_count", 32'(n), 32'd6);
        in_valid = '0;
        repeat (12) @(posedge clk);
        #1;

        // Flush, with a same-cycle in_valid that must be dropped.
        clear    = 1'b1;
        in_valid = 4'b0010;
        in_data  = {4{16'h1234}};
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = '0;
        check_val("clr_drop", 32'(in_ready), 32'hF);
        check_val("clr_ov", 32'(out_valid), 32'd0);

        // Clear during MUL_FB of ch0 aborts the result.
        send(4'b0001, 16'h4000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) n++;
            @(posedge clk); #1;
        end
        check_val("abort_no_pulse", 32'(n), 32'd0);
        send(4'b0001, 16'h4000);
        expect_result("after_abort", 0, 16'h0666, 3);

        // last_grant survives clear: ch0 just served, so ch1 goes first.
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        send(4'b0011, 16'h4000);
        expect_result("lg_kept_ch1", 1, 16'h0666, 3);
        expect_result("lg_kept_ch0", 0, 16'h0666, 3);

        // Reset in the middle of an operation.
        send(4'b0100, 16'h4000);
        @(posedge clk); #1;
        do_reset("rst_mid");
        n = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) n++;
            @(posedge clk); #1;
        end
        check_val("rst_no_pulse", 32'(n), 32'd0);
        send(4'b0001, 16'h4000);
        expect_result("after_rst", 0, 16'h0666, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ema_channel_scheduler.md
EMA_CHANNEL_SCHEDULER -- requirements
Module: ema_channel_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4: number of requesting channels sharing one exponential-averager datapath.
REQ-002 Parameter ALPHA, default 16'sh0CCC: feed-forward coefficient, signed Q1.15 (~0.1).
REQ-003 Parameter BETA, default 16'sh7333: feedback coefficient, signed Q1.15 (~0.9).
REQ-004 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 clear  in  1  synchronous flush pulse: zeroes all channel states and pending buffers.
REQ-007 in_valid  in  NUM_CH  per-channel sample valid.
REQ-008 in_data  in  16*NUM_CH  packed signed Q1.15 samples; channel i is bits [16i+15:16i].
REQ-009 in_ready  out  NUM_CH  per-channel ready; in_ready[i] SHALL equal the inverse of pend[i] (combinational from register).
REQ-010 out_valid  out  1  one-cycle pulse per filtered result.
REQ-011 out_channel  out  $clog2(NUM_CH)  channel index of the result.
REQ-012 out_data  out  16  signed Q1.15 filtered value.

Function
REQ-013 Per channel the block SHALL hold a 1-deep sample buffer buf[i], pending flag pend[i] and a 16-bit filter state y[i].
REQ-014 in_valid[i] and in_ready[i] high at a rising edge SHALL set pend[i]=1 and capture buf[i]; in_valid with in_ready low SHALL be ignored (no overwrite).
REQ-015 FSM states: IDLE, MUL_FF, MUL_FB; one shared 16x16 signed multiplier SHALL be used in both MUL states.
REQ-016 IDLE: if any pend is set, grant round-robin to the first pending channel after last_grant (wrapping NUM_CH-1 to 0), latch it as ch, update last_grant, go to MUL_FF; else stay.
REQ-017 MUL_FF: acc <= bits [30:15] of buf[ch]*ALPHA; clear pend[ch]; go to MUL_FB.
REQ-018 MUL_FB: y_new = acc + bits [30:15] of y[ch]*BETA, 16-bit two's-complement wrap, no saturation; y[ch] <= y_new; out_data <= y_new; out_channel <= ch; out_valid <= 1; go to IDLE.
REQ-019 out_valid SHALL be high exactly the one cycle after MUL_FB, otherwise 0; out_data/out_channel SHALL hold their last value between pulses.
REQ-020 Latency: sample accepted at edge N with FSM idle and no other pend yields out_valid during cycle N+3; peak throughput one result per 3 cycles.
REQ-021 A channel whose pend clears in MUL_FF SHALL accept a new sample no earlier than the edge ending MUL_FF; it is not re-granted before other pending channels (round-robin fairness).
REQ-022 clear SHALL zero y[], pend[], acc, set out_valid=0, force IDLE; in_valid in the same cycle as clear SHALL be dropped; last_grant and out_data/out_channel SHALL be retained.
REQ-023 clear or reset asserted mid-MUL_FF/MUL_FB SHALL abort the operation without updating y or pulsing out_valid.

Reset
REQ-024 reset_n low at an edge SHALL set: FSM=IDLE, pend=0, y=0, buf=0, acc=0, out_valid=0, out_data=0, out_channel=0, last_grant=NUM_CH-1 (channel 0 first).
REQ-025 reset_n SHALL take priority over clear and all handshakes.

Verification
REQ-026 After reset, ch0 sample 0x4000 -> out_valid 3 cycles later, out_channel=0, out_data=0x0666; second ch0 0x4000 -> out_data=0x0C28.
REQ-027 Ch1 sample 0xC000 from zero state -> out_data=0xF99A (floor truncation of negative product), out_channel=1.
REQ-028 All four in_valid high one cycle after reset with 0x4000 -> results in channel order 0,1,2,3, pulses 3 cycles apart, each 0x0666; in_ready[i] low until that channel's MUL_FF.
REQ-029 in_valid[2] held high continuously while ch0 and ch3 also stream -> grants rotate 0,2,3,0,2,3...; no channel served twice consecutively while another is pending.
REQ-030 clear pulsed during MUL_FB of ch0 -> no out_valid, y[0]=0, next 0x4000 on ch0 yields 0x0666; reset_n low mid-operation -> all outputs return to REQ-024 values.
